// File: rtl/seq_shift_add_mult_pkg.sv
// Shared constants for the sequential shift-and-add multiplier.
// The operand width is a module parameter, so the step counter is sized
// for the largest legal width and the legality check lives here.
package seq_shift_add_mult_pkg;

    // Legal operand widths.
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

    // The step counter only has to reach WIDTH_MAX-1.
    localparam int CNT_W = $clog2(WIDTH_MAX);

    // FSM encodings.
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    // Returns 1 when the requested operand width is supported.
    function automatic bit width_ok(input int width);
        return (width >= WIDTH_MIN) && (width <= WIDTH_MAX);
    endfunction

endpackage : seq_shift_add_mult_pkg

// File: rtl/seq_shift_add_mult_step.sv
// One shift-and-add iteration: conditionally add the multiplicand into the
// upper half of the accumulator, then shift the whole accumulator right by
// one with the adder carry entering the MSB. Purely combinational so that
// other benches can use it as a golden single step.
module seq_shift_add_mult_step #(
    parameter int WIDTH = 4
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mcand,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] addend;

    // Add the multiplicand only when the current multiplier bit is set.
    // The sum is one bit wider than the operands; that carry becomes the
    // new MSB after the shift.
    always_comb begin
        addend   = acc[0] ? mcand : '0;
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        acc_next = {sum, acc[WIDTH-1:1]};
    end

endmodule : seq_shift_add_mult_step

// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per clock.
// Fixed latency of WIDTH cycles from the accepting edge; no early exit.
//
// state | meaning
// IDLE  | waiting for start; product holds the last result
// RUN   | iterating, one multiplier bit consumed per clock
module seq_shift_add_mult
    import seq_shift_add_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     data_a,
    input  logic [WIDTH-1:0]     data_b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("seq_shift_add_mult: WIDTH=%0d outside %0d..%0d",
                   WIDTH, WIDTH_MIN, WIDTH_MAX);
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic                 state;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [CNT_W-1:0]     count;
    logic                 accept;
    logic                 last_step;

    seq_shift_add_mult_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (acc),
        .mcand    (mcand),
        .acc_next (acc_next)
    );

    // Start is honoured only in IDLE; an X on start does not take the branch.
    always_comb begin
        accept    = 1'b0;
        last_step = 1'b0;
        if (state == ST_IDLE && start == 1'b1) begin
            accept = 1'b1;
        end
        if (state == ST_RUN && count == LAST_STEP) begin
            last_step = 1'b1;
        end
    end

    // FSM, operand capture and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            mcand <= '0;
            acc   <= '0;
            count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        mcand <= data_a;
                        acc   <= {{WIDTH{1'b0}}, data_b};
                        count <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (last_step) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status outputs: busy covers the WIDTH iteration cycles, done is a
    // single-cycle strobe after the final step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= last_step;
            if (accept) begin
                busy <= 1'b1;
            end else if (last_step) begin
                busy <= 1'b0;
            end
        end
    end

    // The product register moves only on a completion; a new start leaves
    // the previous result visible until the next one lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
        end else if (last_step) begin
            product <= acc_next;
        end
    end

endmodule : seq_shift_add_mult

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for the shift-and-add multiplier (WIDTH=4).
module tb_seq_shift_add_mult;

    localparam int W = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   data_a;
    logic [W-1:0]   data_b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks = 0;
    int errors = 0;

    seq_shift_add_mult #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data_a  (data_a),
        .data_b  (data_b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after an active edge; presents operands and start for the
    // next edge (edge N), returns #1 after edge N with start dropped.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        data_a = a;
        data_b = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    // Counts edges until done is seen; a missing done is a failed check.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 3 * W + 4; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) check_val("done_timeout", 32'd0, 32'd1);
    endtask

    int lat;
    int busy_cycles;
    logic saw_done;
    logic [31:0] q_times_b;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        data_a = '0;
        data_b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle after reset with no start.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_val("idle_busy", {31'd0, busy}, 32'd0);
            check_val("idle_done", {31'd0, done}, 32'd0);
            check_val("idle_product", {24'd0, product}, 32'h00);
        end

        // 13*11 with busy width and latency.
        start_op(4'd13, 4'd11);
        busy_cycles = 0;
        lat = 0;
        if (busy) busy_cycles++;
        for (int i = 1; i <= 3 * W; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_cycles++;
        end
        check_val("13x11_busy_cycles", busy_cycles, W);
        check_val("13x11_latency", lat, W);
        check_val("13x11_busy_at_done", {31'd0, busy}, 32'd0);
        check_val("13x11_product", {24'd0, product}, 32'h8F);
        @(posedge clk);
        #1;
        check_val("13x11_done_one_cycle", {31'd0, done}, 32'd0);
        check_val("13x11_product_held", {24'd0, product}, 32'h8F);

        // Carry path.
        start_op(4'd15, 4'd15);
        wait_done(lat);
        check_val("15x15_latency", lat, W);
        check_val("15x15_product", {24'd0, product}, 32'hE1);

        // Zero multiplicand keeps full latency.
        start_op(4'd0, 4'd9);
        check_val("0x9_product_not_cleared", {24'd0, product}, 32'hE1);
        wait_done(lat);
        check_val("0x9_latency", lat, W);
        check_val("0x9_product", {24'd0, product}, 32'h00);

        // Back-to-back: second start during the done cycle.
        start_op(4'd3, 4'd5);
        wait_done(lat);
        check_val("b2b_first_latency", lat, W);
        check_val("b2b_first_product", {24'd0, product}, 32'h0F);
        start_op(4'd7, 4'd6);
        check_val("b2b_done_dropped", {31'd0, done}, 32'd0);
        check_val("b2b_busy_again", {31'd0, busy}, 32'd1);
        check_val("b2b_product_kept", {24'd0, product}, 32'h0F);
        wait_done(lat);
        check_val("b2b_second_latency", lat, W);
        check_val("b2b_second_product", {24'd0, product}, 32'h2A);

        // Start while busy is ignored, as are operand changes.
        start_op(4'd9, 4'd9);
        @(posedge clk);
        #1;
        data_a = 4'd1;
        data_b = 4'd1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        wait_done(lat);
        check_val("busy_start_latency", lat, W - 2);
        check_val("busy_start_product", {24'd0, product}, 32'h51);
        @(posedge clk);
        #1;
        check_val("busy_start_no_rerun", {31'd0, busy}, 32'd0);

        // Reset mid-operation aborts without a done.
        start_op(4'd12, 4'd12);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        check_val("abort_product", {24'd0, product}, 32'h00);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        check_val("abort_no_done", {31'd0, saw_done}, 32'd0);
        check_val("abort_product_after", {24'd0, product}, 32'h00);
        start_op(4'd2, 4'd3);
        wait_done(lat);
        check_val("after_abort_latency", lat, W);
        check_val("after_abort_product", {24'd0, product}, 32'h06);

        // X on start is treated as no request.
        @(posedge clk);
        #1;
        start = 1'bx;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_val("x_start_busy", {31'd0, busy}, 32'd0);

        // Exhaustive products, plus quotient*divisor + remainder rebuilds a.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                start_op(a[W-1:0], b[W-1:0]);
                wait_done(lat);
                check_val($sformatf("exh_%0dx%0d", a, b), {24'd0, product}, a * b);
                if (b != 0) begin
                    start_op(4'(a / b), b[W-1:0]);
                    wait_done(lat);
                    q_times_b = {24'd0, product} + 32'(a % b);
                    check_val($sformatf("div_rebuild_%0d_%0d", a, b), q_times_b, a);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_shift_add_mult
